alu_fu_pipe: RTL and testbench

ALU_FU_PIPE -- requirements
Module: alu_fu_pipe

---
 rtl/alu_fu_pipe.sv | 182 ++++++++++++++++++
 tb/tb_alu_fu_pipe.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_fu_pipe.sv
// ALU functional unit: computes one op per issue and queues the result for CDB and ROB delivery.
// Latency: 1 cycle from accepted issue to result at the head when the buffer is empty.
// Backpressure: busy while all DEPTH entries are held; the head pops only after both channels have taken it.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   input_transmit, opcode,       issue valid, operation, operands,
//   operand_a/b, wbs, flags,      writeback selector, flags (bit0 = carry-in),
//   robid                         and ROB id of the issued op
//   cdb_transmit / _out, cdb_id,  CDB grant / valid, tag and result of the head entry
//   cdb_val
//   rob_transmit / _out,          ROB grant / valid and full head-entry payload
//   robid_out, flags_out,
//   wbs_out, value_out
//   busy                          issue stall (buffer full)
module alu_fu_pipe #(
    parameter int DATA_W  = 8,
    parameter int ROBID_W = 8,
    parameter int TAG_W   = 4,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               input_transmit,
    input  logic [3:0]         opcode,
    input  logic [DATA_W-1:0]  operand_a,
    input  logic [DATA_W-1:0]  operand_b,
    input  logic [7:0]         wbs,
    input  logic [7:0]         flags,
    input  logic [ROBID_W-1:0] robid,
    input  logic               cdb_transmit,
    output logic               cdb_transmit_out,
    output logic [TAG_W-1:0]   cdb_id,
    output logic [DATA_W-1:0]  cdb_val,
    input  logic               rob_transmit,
    output logic               rob_transmit_out,
    output logic [ROBID_W-1:0] robid_out,
    output logic [7:0]         flags_out,
    output logic [7:0]         wbs_out,
    output logic [DATA_W-1:0]  value_out,
    output logic               busy
);
    localparam int MSB   = DATA_W - 1;
    localparam int SH_W  = $clog2(DATA_W);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [3:0] OP_ADD = 4'd0,  OP_ADC = 4'd1,  OP_SUB = 4'd2,  OP_SBC = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4,  OP_OR  = 4'd5,  OP_XOR = 4'd6,  OP_PASS = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8,  OP_SHR = 4'd9,  OP_SAR = 4'd10, OP_CMP = 4'd11;

    // ---------------- ALU ----------------
    logic [DATA_W:0]   w_cin_x;
    logic [SH_W-1:0]   w_sh;
    logic [DATA_W:0]   w_add_x, w_sub_x, w_shl_x, w_shr_x, w_sar_x;
    logic [DATA_W-1:0] w_res;
    logic              w_c, w_z, w_n, w_v, w_ill, w_cmp, w_no_cdb;
    logic [7:0]        w_flags;
    logic              w_unused_flags;

    assign w_unused_flags = ^flags[7:1];
    assign w_cin_x = {{DATA_W{1'b0}}, flags[0]};
    assign w_sh    = operand_b[SH_W-1:0];

    // The extra bit of each shift catches the last bit shifted out (zero when w_sh == 0).
    assign w_add_x = {1'b0, operand_a} + {1'b0, operand_b} + ((opcode == OP_ADC) ? w_cin_x : '0);
    assign w_sub_x = {1'b0, operand_a} - {1'b0, operand_b} - ((opcode == OP_SBC) ? w_cin_x : '0);
    assign w_shl_x = {1'b0, operand_a} << w_sh;
    assign w_shr_x = {operand_a, 1'b0} >> w_sh;
    assign w_sar_x = $signed({operand_a, 1'b0}) >>> w_sh;

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_ill = 1'b0;
        w_cmp = 1'b0;
        case (opcode)
            OP_ADD, OP_ADC: begin
                w_res = w_add_x[MSB:0];
                w_c   = w_add_x[DATA_W];
                w_v   = (operand_a[MSB] == operand_b[MSB]) && (w_add_x[MSB] != operand_a[MSB]);
            end
            OP_SUB, OP_SBC, OP_CMP: begin
                w_res = (opcode == OP_CMP) ? operand_a : w_sub_x[MSB:0];
                w_cmp = (opcode == OP_CMP);
                w_c   = w_sub_x[DATA_W];   // borrow
                w_v   = (operand_a[MSB] != operand_b[MSB]) && (w_sub_x[MSB] != operand_a[MSB]);
            end
            OP_AND:  w_res = operand_a & operand_b;
            OP_OR:   w_res = operand_a | operand_b;
            OP_XOR:  w_res = operand_a ^ operand_b;
            OP_PASS: w_res = operand_b;
            OP_SHL: begin
                w_res = w_shl_x[MSB:0];
                w_c   = w_shl_x[DATA_W];
            end
            OP_SHR: begin
                w_res = w_shr_x[DATA_W:1];
                w_c   = w_shr_x[0];
            end
            OP_SAR: begin
                w_res = w_sar_x[DATA_W:1];
                w_c   = w_sar_x[0];
            end
            default: w_ill = 1'b1;
        endcase
    end

    // CMP reports Z/N of the difference; illegal ops report only the illegal bit.
    assign w_z      = !w_ill && (w_cmp ? (w_sub_x[MSB:0] == '0) : (w_res == '0));
    assign w_n      = !w_ill && (w_cmp ? w_sub_x[MSB] : w_res[MSB]);
    assign w_flags  = {w_ill, 3'b000, w_v, w_n, w_z, w_c};
    assign w_no_cdb = w_cmp || w_ill;

    // ---------------- result buffer ----------------
    logic [DATA_W-1:0]  r_val   [DEPTH];
    logic [7:0]         r_flg   [DEPTH];
    logic [7:0]         r_wbs   [DEPTH];
    logic [ROBID_W-1:0] r_rid   [DEPTH];
    logic [DEPTH-1:0]   r_cdb_done, r_rob_done;
    logic [PTR_W-1:0]   r_head, r_tail;
    logic [CNT_W-1:0]   r_count;

    logic w_head_vld, w_push, w_pop, w_cdb_xfer, w_rob_xfer;

    assign busy             = (r_count == CNT_W'(DEPTH));
    assign w_head_vld       = (r_count != '0);
    assign w_push           = input_transmit && !busy;
    assign cdb_transmit_out = w_head_vld && !r_cdb_done[r_head];
    assign rob_transmit_out = w_head_vld && !r_rob_done[r_head];
    assign w_cdb_xfer       = cdb_transmit_out && cdb_transmit;
    assign w_rob_xfer       = rob_transmit_out && rob_transmit;
    // Pop once both channels are done, counting a transfer happening at this edge.
    assign w_pop            = w_head_vld && (r_cdb_done[r_head] || w_cdb_xfer)
                                         && (r_rob_done[r_head] || w_rob_xfer);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_cdb_done <= '0;
            r_rob_done <= '0;
        end else begin
            // Tail and head coincide only when empty (no transfer) or full (no push).
            if (w_push) begin
                r_tail             <= r_tail + PTR_W'(1);
                r_cdb_done[r_tail] <= w_no_cdb;
                r_rob_done[r_tail] <= 1'b0;
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end else begin
                if (w_cdb_xfer) r_cdb_done[r_head] <= 1'b1;
                if (w_rob_xfer) r_rob_done[r_head] <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset: outputs are gated by the channel valids.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_val[r_tail] <= w_res;
            r_flg[r_tail] <= w_flags;
            r_wbs[r_tail] <= wbs;
            r_rid[r_tail] <= robid;
        end
    end

    assign cdb_id    = cdb_transmit_out ? r_wbs[r_head][TAG_W-1:0] : '0;
    assign cdb_val   = cdb_transmit_out ? r_val[r_head] : '0;
    assign robid_out = rob_transmit_out ? r_rid[r_head] : '0;
    assign flags_out = rob_transmit_out ? r_flg[r_head] : '0;
    assign wbs_out   = rob_transmit_out ? r_wbs[r_head] : '0;
    assign value_out = rob_transmit_out ? r_val[r_head] : '0;
endmodule

// File: tb/tb_alu_fu_pipe.sv
// Bench for alu_fu_pipe: directed issue/grant sequences checked against a queue-based model
// every cycle, plus literal expectations on the hand-computed vectors.
// Outputs are sampled on the falling edge; inputs change 1ns after the rising edge.
module tb_alu_fu_pipe;
    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       input_transmit;
    logic [3:0] opcode;
    logic [7:0] operand_a, operand_b, wbs, flags, robid;
    logic       cdb_transmit, cdb_transmit_out;
    logic [3:0] cdb_id;
    logic [7:0] cdb_val;
    logic       rob_transmit, rob_transmit_out;
    logic [7:0] robid_out, flags_out, wbs_out, value_out;
    logic       busy;

    alu_fu_pipe #(.DATA_W(8), .ROBID_W(8), .TAG_W(4), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .input_transmit(input_transmit), .opcode(opcode),
        .operand_a(operand_a), .operand_b(operand_b), .wbs(wbs), .flags(flags),
        .robid(robid), .cdb_transmit(cdb_transmit), .cdb_transmit_out(cdb_transmit_out),
        .cdb_id(cdb_id), .cdb_val(cdb_val), .rob_transmit(rob_transmit),
        .rob_transmit_out(rob_transmit_out), .robid_out(robid_out), .flags_out(flags_out),
        .wbs_out(wbs_out), .value_out(value_out), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        logic [7:0] val, flg, wbs, rid;
        bit         nocdb;
    } ent_t;

    ent_t       mq[$];
    bit         cdone = 0, rdone = 0, model_live = 0;
    logic [7:0] dlog[$];

    function automatic ent_t alu_model(input logic [3:0] op, input logic [7:0] a, b, f,
                                       input logic [7:0] w, rid);
        ent_t e;
        logic signed [7:0] as_ = a, bs_ = b;
        int ua = a, ub = b, sa = as_, sb = bs_, cin = f[0], s = b[2:0];
        int r = 0, c = 0, v = 0, zsrc, ill = 0, sr;
        case (op)
            0, 1: begin
                r = ua + ub + ((op == 1) ? cin : 0);
                c = (r > 255);
                sr = sa + sb + ((op == 1) ? cin : 0);
                v = (sr > 127 || sr < -128);
            end
            2, 3, 11: begin
                r = ua - ub - ((op == 3) ? cin : 0);
                c = (r < 0);
                sr = sa - sb - ((op == 3) ? cin : 0);
                v = (sr > 127 || sr < -128);
            end
            4: r = ua & ub;
            5: r = ua | ub;
            6: r = ua ^ ub;
            7: r = ub;
            8: begin r = ua << s; c = (r >> W) & 1; end
            9: begin r = ua >> s; c = (s == 0) ? 0 : ((ua >> (s - 1)) & 1); end
            10: begin r = sa >>> s; c = (s == 0) ? 0 : ((ua >> (s - 1)) & 1); end
            default: ill = 1;
        endcase
        zsrc  = r & 255;   // for CMP this is the difference
        e.val = (op == 11) ? a : 8'(zsrc);
        if (ill != 0) e.flg = 8'h80;
        else e.flg = {4'b0000, v[0], (zsrc >= 128), (zsrc == 0), c[0]};
        e.wbs   = w;
        e.rid   = rid;
        e.nocdb = (op == 11) || (ill != 0);
        return e;
    endfunction

    // Model state advance, mirroring what the interface rules say happens at each edge.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            mq.delete();
            cdone = 0;
            rdone = 0;
            model_live = 1;
        end else if (model_live) begin
            bit has, cx, rx, pop;
            if (rob_transmit_out && rob_transmit) dlog.push_back(robid_out);
            has = (mq.size() > 0);
            cx  = has && !mq[0].nocdb && !cdone && cdb_transmit;
            rx  = has && !rdone && rob_transmit;
            pop = has && (mq[0].nocdb || cdone || cx) && (rdone || rx);
            if (input_transmit && mq.size() < 4)
                mq.push_back(alu_model(opcode, operand_a, operand_b, flags, wbs, robid));
            if (pop) begin
                void'(mq.pop_front());
                cdone = 0;
                rdone = 0;
            end else begin
                cdone = cdone | cx;
                rdone = rdone | rx;
            end
        end
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (model_live && !rst) begin
            bit   has, ecv, erv;
            ent_t h;
            has = (mq.size() > 0);
            if (has) h = mq[0];
            else h = '{val: 0, flg: 0, wbs: 0, rid: 0, nocdb: 0};
            ecv = has && !h.nocdb && !cdone;
            erv = has && !rdone;
            chk("cdb_vld",   cdb_transmit_out, ecv);
            chk("cdb_id",    cdb_id,    ecv ? h.wbs[3:0] : 4'h0);
            chk("cdb_val",   cdb_val,   ecv ? h.val : 8'h0);
            chk("rob_vld",   rob_transmit_out, erv);
            chk("robid_out", robid_out, erv ? h.rid : 8'h0);
            chk("flags_out", flags_out, erv ? h.flg : 8'h0);
            chk("wbs_out",   wbs_out,   erv ? h.wbs : 8'h0);
            chk("value_out", value_out, erv ? h.val : 8'h0);
            chk("busy",      busy,      mq.size() == 4);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [3:0] op, input logic [7:0] a, b, w, rid);
        opcode = op; operand_a = a; operand_b = b; wbs = w; robid = rid; flags = 8'h00;
    endtask

    task automatic issue(input logic [3:0] op, input logic [7:0] a, b, w, rid);
        set_op(op, a, b, w, rid);
        input_transmit = 1'b1;
        tick();
        input_transmit = 1'b0;
    endtask

    task automatic grant_both();
        cdb_transmit = 1'b1;
        rob_transmit = 1'b1;
        tick();
        cdb_transmit = 1'b0;
        rob_transmit = 1'b0;
    endtask

    initial begin
        ent_t e;
        logic [7:0] exp_order[10];
        rst = 1'b1; input_transmit = 1'b0; cdb_transmit = 1'b0; rob_transmit = 1'b0;
        set_op(4'd0, 8'h00, 8'h00, 8'h00, 8'h00);

        // Pin the model itself with hand-computed results.
        e = alu_model(4'd0, 8'h7F, 8'h01, 8'h00, 8'h15, 8'h03);
        chk("model_add_val", e.val, 8'h80);
        chk("model_add_flg", e.flg, 8'h0C);
        e = alu_model(4'd3, 8'h10, 8'h01, 8'h01, 8'h00, 8'h00);
        chk("model_sbc_val", e.val, 8'h0E);
        e = alu_model(4'd10, 8'h83, 8'h01, 8'h00, 8'h00, 8'h00);
        chk("model_sar_val", e.val, 8'hC1);
        chk("model_sar_flg", e.flg, 8'h05);

        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cdb_vld", cdb_transmit_out, 0);
        chk("rst_rob_vld", rob_transmit_out, 0);
        chk("rst_busy", busy, 0);

        // ADD with signed overflow
        issue(4'd0, 8'h7F, 8'h01, 8'h15, 8'h03);
        @(negedge clk);
        chk("add_cdb_id", cdb_id, 4'h5);
        chk("add_cdb_val", cdb_val, 8'h80);
        chk("add_value", value_out, 8'h80);
        chk("add_flags", flags_out, 8'h0C);
        chk("add_robid", robid_out, 8'h03);
        grant_both();
        @(negedge clk);
        chk("add_popped_cdb", cdb_transmit_out, 0);
        chk("add_popped_rob", rob_transmit_out, 0);

        issue(4'd2, 8'h00, 8'h01, 8'h01, 8'h04);
        @(negedge clk);
        chk("sub_value", value_out, 8'hFF);
        chk("sub_flags", flags_out, 8'h05);
        grant_both();

        issue(4'd8, 8'h81, 8'h01, 8'h02, 8'h05);
        @(negedge clk);
        chk("shl_value", value_out, 8'h02);
        chk("shl_flags", flags_out, 8'h01);
        grant_both();

        issue(4'd11, 8'h05, 8'h05, 8'h03, 8'h06);
        @(negedge clk);
        chk("cmp_cdb_vld", cdb_transmit_out, 0);
        chk("cmp_value", value_out, 8'h05);
        chk("cmp_flags", flags_out, 8'h02);
        grant_both();

        issue(4'd13, 8'h12, 8'h34, 8'h04, 8'h07);
        @(negedge clk);
        chk("ill_cdb_vld", cdb_transmit_out, 0);
        chk("ill_rob_vld", rob_transmit_out, 1);
        chk("ill_value", value_out, 8'h00);
        chk("ill_flags", flags_out, 8'h80);
        grant_both();

        // Fill to full with grants low; the fifth issue must be dropped.
        dlog.delete();
        input_transmit = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_op(4'd0, 8'(i * 37), 8'(i * 11), 8'(i), 8'(8'h10 + i));
            if (i == 4) begin
                @(negedge clk);
                chk("full_busy", busy, 1);
            end
            tick();
        end
        input_transmit = 1'b0;
        @(negedge clk);
        chk("full_head", robid_out, 8'h10);
        grant_both();
        @(negedge clk);
        chk("after_pop_busy", busy, 0);
        chk("after_pop_head", robid_out, 8'h11);
        cdb_transmit = 1'b1;
        rob_transmit = 1'b1;
        input_transmit = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_op(4'(i * 3), 8'(8'hA5 + i * 29), 8'(i + 1), 8'(8'h20 + i), 8'(8'h20 + i));
            tick();
        end
        input_transmit = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        cdb_transmit = 1'b0;
        rob_transmit = 1'b0;
        exp_order = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
        chk("order_count", dlog.size(), 10);
        for (int i = 0; i < 10; i++)
            chk("order_robid", (i < dlog.size()) ? dlog[i] : 8'hXX, exp_order[i]);

        // Split grant: CDB taken first, ROB two cycles later.
        issue(4'd5, 8'h30, 8'h03, 8'h0A, 8'h30);
        issue(4'd6, 8'h0F, 8'hFF, 8'h0B, 8'h31);
        cdb_transmit = 1'b1;
        tick();
        cdb_transmit = 1'b0;
        @(negedge clk);
        chk("split_c2_cdb", cdb_transmit_out, 0);
        chk("split_c2_rob", rob_transmit_out, 1);
        tick();
        rob_transmit = 1'b1;
        @(negedge clk);
        chk("split_c3_robid", robid_out, 8'h30);
        tick();
        rob_transmit = 1'b0;
        @(negedge clk);
        chk("split_c4_robid", robid_out, 8'h31);
        chk("split_c4_cdb", cdb_transmit_out, 1);
        chk("split_c4_val", cdb_val, 8'hF0);
        grant_both();

        // Reset with two held entries, a pending issue and grants all asserted.
        issue(4'd0, 8'h01, 8'h01, 8'h01, 8'h40);
        issue(4'd0, 8'h02, 8'h02, 8'h02, 8'h41);
        rst = 1'b1;
        input_transmit = 1'b1;
        cdb_transmit = 1'b1;
        rob_transmit = 1'b1;
        tick();
        rst = 1'b0;
        input_transmit = 1'b0;
        cdb_transmit = 1'b0;
        rob_transmit = 1'b0;
        @(negedge clk);
        chk("rst2_cdb_vld", cdb_transmit_out, 0);
        chk("rst2_rob_vld", rob_transmit_out, 0);
        chk("rst2_busy", busy, 0);
        chk("rst2_value", value_out, 0);
        chk("rst2_cdb_val", cdb_val, 0);
        issue(4'd0, 8'h03, 8'h04, 8'h09, 8'h42);
        @(negedge clk);
        chk("post_rst_value", value_out, 8'h07);
        chk("post_rst_robid", robid_out, 8'h42);
        chk("post_rst_cdb_id", cdb_id, 4'h9);
        grant_both();
        @(negedge clk);
        chk("final_empty", rob_transmit_out, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
